// File: rtl/paillier_pkg.sv
// Shared sizes and stream state encoding for the Paillier datapath constant streamers.
package paillier_pkg;

  localparam int REGISTER_SIZE        = 32;
  localparam int N_SQUARED_SIZE       = 4096;
  localparam int NUM_N_SQUARED_BLOCKS = N_SQUARED_SIZE / REGISTER_SIZE;

  typedef enum logic {IDLE, STREAM} stream_state_t;

endpackage

// File: rtl/block_stream_channel.sv
// One constant's storage bank plus its block-stream FSM with index and pass counters.
//   state  | meaning
//   IDLE   | no stream; storage writable, outputs zero
//   STREAM | presenting storage[idx] with valid until the final block of the final pass is taken
module block_stream_channel
  import paillier_pkg::*;
#(
  parameter int BLOCK_W   = 32,
  parameter int DEPTH     = 128,
  parameter int MSB_FIRST = 0,
  parameter int PASS_W    = 8,
  parameter int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_index,
  input  logic [BLOCK_W-1:0] wr_data,
  input  logic              start,
  input  logic [PASS_W-1:0] passes,
  input  logic              abort,
  input  logic              ready,
  output logic              valid,
  output logic [BLOCK_W-1:0] data,
  output logic [IW-1:0]     index,
  output logic              last,
  output logic              done,
  output logic              busy
);

  localparam logic [IW-1:0] FIRST_IDX = (MSB_FIRST != 0) ? IW'(DEPTH - 1) : '0;
  localparam logic [IW-1:0] END_IDX   = (MSB_FIRST != 0) ? '0 : IW'(DEPTH - 1);

  stream_state_t       state;
  logic [IW-1:0]       idx;
  logic [PASS_W-1:0]   pass_cnt;
  logic [BLOCK_W-1:0]  mem [DEPTH];
  logic                at_end;
  logic                final_pass;

  assign at_end     = (idx == END_IDX);
  assign final_pass = (pass_cnt == PASS_W'(1));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      idx      <= '0;
      pass_cnt <= '0;
      done     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      if (wr_en) mem[wr_index] <= wr_data;
      // abort outranks start; a restart discards any handshake in the same cycle
      if (abort) begin
        state <= IDLE;
      end else if (start) begin
        state    <= STREAM;
        idx      <= FIRST_IDX;
        pass_cnt <= (passes == '0) ? PASS_W'(1) : passes;
      end else if (state == STREAM && ready) begin
        if (at_end) begin
          idx <= FIRST_IDX;
          if (final_pass) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            pass_cnt <= pass_cnt - 1'b1;
          end
        end else begin
          idx <= (MSB_FIRST != 0) ? idx - 1'b1 : idx + 1'b1;
        end
      end
    end
  end

  assign valid = (state == STREAM);
  assign busy  = valid;
  assign data  = valid ? mem[idx] : '0;
  assign index = valid ? idx : '0;
  assign last  = valid & at_end & final_pass;

endmodule

// File: rtl/const_block_streamer.sv
// Multi-channel constant block streamer: decodes block loads and fans out independent stream channels.
module const_block_streamer #(
  parameter int REGISTER_SIZE = paillier_pkg::REGISTER_SIZE,
  parameter int NUM_BLOCKS    = paillier_pkg::NUM_N_SQUARED_BLOCKS,
  parameter int NUM_CHANNELS  = 3,
  parameter int MSB_FIRST     = 0,
  parameter int PASS_W        = 8,
  parameter int CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int IDX_W         = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic                                       load_valid_in,
  input  logic [CH_W-1:0]                            load_channel_in,
  input  logic [IDX_W-1:0]                           load_index_in,
  input  logic [REGISTER_SIZE-1:0]                   load_data_in,
  output logic                                       load_err_out,
  input  logic [NUM_CHANNELS-1:0]                    start_in,
  input  logic [NUM_CHANNELS-1:0][PASS_W-1:0]        passes_in,
  input  logic [NUM_CHANNELS-1:0]                    abort_in,
  input  logic [NUM_CHANNELS-1:0]                    ready_in,
  output logic [NUM_CHANNELS-1:0]                    valid_out,
  output logic [NUM_CHANNELS-1:0][REGISTER_SIZE-1:0] data_out,
  output logic [NUM_CHANNELS-1:0][IDX_W-1:0]         index_out,
  output logic [NUM_CHANNELS-1:0]                    last_out,
  output logic [NUM_CHANNELS-1:0]                    done_out,
  output logic [NUM_CHANNELS-1:0]                    busy_out
);

  localparam logic [CH_W:0]  CH_LIMIT  = (CH_W + 1)'(NUM_CHANNELS);
  localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W + 1)'(NUM_BLOCKS);

  logic                    ch_ok;
  logic                    idx_ok;
  logic                    tgt_busy;
  logic                    load_ok;
  logic [NUM_CHANNELS-1:0] ch_wr;

  // Out-of-range channels never match, so they read as not busy and fail ch_ok instead.
  always_comb begin
    tgt_busy = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (load_channel_in == CH_W'(c)) tgt_busy = busy_out[c];
    end
  end

  assign ch_ok   = ({1'b0, load_channel_in} < CH_LIMIT);
  assign idx_ok  = ({1'b0, load_index_in} < IDX_LIMIT);
  assign load_ok = load_valid_in & ch_ok & idx_ok & ~tgt_busy;

  always_ff @(posedge clk_in) begin
    if (!rst_in) load_err_out <= 1'b0;
    else         load_err_out <= load_valid_in & ~load_ok;
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign ch_wr[g] = load_ok & (load_channel_in == CH_W'(g));

    block_stream_channel #(
      .BLOCK_W   (REGISTER_SIZE),
      .DEPTH     (NUM_BLOCKS),
      .MSB_FIRST (MSB_FIRST),
      .PASS_W    (PASS_W),
      .IW        (IDX_W)
    ) u_channel (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .wr_en    (ch_wr[g]),
      .wr_index (load_index_in),
      .wr_data  (load_data_in),
      .start    (start_in[g]),
      .passes   (passes_in[g]),
      .abort    (abort_in[g]),
      .ready    (ready_in[g]),
      .valid    (valid_out[g]),
      .data     (data_out[g]),
      .index    (index_out[g]),
      .last     (last_out[g]),
      .done     (done_out[g]),
      .busy     (busy_out[g])
    );
  end

endmodule
